rr_decoder_arbiter: RTL and testbench

Four-requester round-robin arbiter that time-shares one resource. Each grant is encoded as a 2-bit address plus an enable, which drive the 2-to-4 decoder's address0/address1/enable inputs. The arbiter also provides a registered one-hot grant. It sequences ownership with a hold limit and a mandatory one-cycle dead gap between owners, so decoder outputs never overlap during a handoff.

---
 rtl/rr_decoder_arbiter.sv | 116 +++++++++++
 tb/tb_rr_decoder_arbiter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/rr_decoder_arbiter.sv
// rtl/rr_decoder_arbiter.sv - four-requester round-robin arbiter with hold limit and dead gap
module rr_decoder_arbiter #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned HOLD_W   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       arb_en,
  input  logic [3:0] req,
  output logic [1:0] grant_addr,
  output logic       grant_valid,
  output logic [3:0] grant,
  output logic       busy,
  output logic       preempt
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  // Counter value on the last allowed grant cycle; unused when MAX_HOLD is 0.
  localparam logic [HOLD_W-1:0] LAST_CNT = (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);

  state_t            state, state_d;
  logic [1:0]        ptr, ptr_d;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_d;
  logic [1:0]        grant_addr_d;
  logic              grant_valid_d;
  logic [3:0]        grant_d;
  logic              busy_d;
  logic              preempt_d;

  logic [1:0]        win;
  logic [1:0]        idx;
  logic              owner_req;
  logic              expire;

  // Round-robin search starting at ptr; scanning from the farthest offset down
  // leaves the nearest requester as the final assignment.
  always_comb begin
    win = ptr;
    idx = ptr;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (req[idx]) win = idx;
    end
  end

  assign owner_req = req[grant_addr];
  assign expire    = (MAX_HOLD != 0) && (hold_cnt == LAST_CNT);

  // Next-state and next-output logic; every output is registered.
  always_comb begin
    state_d       = state;
    ptr_d         = ptr;
    hold_cnt_d    = hold_cnt;
    grant_addr_d  = grant_addr;
    grant_valid_d = grant_valid;
    grant_d       = grant;
    busy_d        = busy;
    preempt_d     = 1'b0;
    case (state)
      GRANT: begin
        if (!owner_req || expire) begin
          // A dropped request wins over simultaneous expiry, so no preempt then.
          state_d       = GAP;
          ptr_d         = grant_addr + 2'd1;
          grant_valid_d = 1'b0;
          grant_d       = 4'b0000;
          busy_d        = 1'b0;
          preempt_d     = owner_req;
        end else if (hold_cnt != '1) begin
          hold_cnt_d = hold_cnt + 1'b1;
        end
      end
      default: begin
        // IDLE and GAP arbitrate identically; grant_addr keeps its old value when idle.
        if (arb_en && (req != 4'b0000)) begin
          state_d       = GRANT;
          grant_addr_d  = win;
          grant_valid_d = 1'b1;
          grant_d       = 4'b0001 << win;
          busy_d        = 1'b1;
          hold_cnt_d    = '0;
        end else begin
          state_d       = IDLE;
          grant_valid_d = 1'b0;
          grant_d       = 4'b0000;
          busy_d        = 1'b0;
        end
      end
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= 2'd0;
      hold_cnt    <= '0;
      grant_addr  <= 2'd0;
      grant_valid <= 1'b0;
      grant       <= 4'b0000;
      busy        <= 1'b0;
      preempt     <= 1'b0;
    end else begin
      state       <= state_d;
      ptr         <= ptr_d;
      hold_cnt    <= hold_cnt_d;
      grant_addr  <= grant_addr_d;
      grant_valid <= grant_valid_d;
      grant       <= grant_d;
      busy        <= busy_d;
      preempt     <= preempt_d;
    end
  end

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// tb/tb_rr_decoder_arbiter.sv - directed vector bench for rr_decoder_arbiter
module tb_rr_decoder_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       arb_en = 1'b1;
  logic [3:0] req = 4'b0000;

  logic [1:0] a2, a8, a0;
  logic       v2, v8, v0;
  logic [3:0] g2, g8, g0;
  logic       b2, b8, b0;
  logic       p2, p8, p0;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rr_decoder_arbiter #(.MAX_HOLD(2), .HOLD_W(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .arb_en(arb_en), .req(req),
    .grant_addr(a2), .grant_valid(v2), .grant(g2), .busy(b2), .preempt(p2));

  rr_decoder_arbiter #(.MAX_HOLD(8), .HOLD_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .arb_en(arb_en), .req(req),
    .grant_addr(a8), .grant_valid(v8), .grant(g8), .busy(b8), .preempt(p8));

  rr_decoder_arbiter #(.MAX_HOLD(0), .HOLD_W(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .arb_en(arb_en), .req(req),
    .grant_addr(a0), .grant_valid(v0), .grant(g0), .busy(b0), .preempt(p0));

  typedef struct {
    logic       rst_n;
    logic       en;
    logic [3:0] req;
    logic [3:0] g;
    logic       v;
    logic [1:0] a;
    logic       p;
  } vec_t;

  vec_t tbl[40];

  function automatic vec_t mk(logic r, logic e, logic [3:0] q, logic [3:0] g, logic v, logic [1:0] a, logic p);
    vec_t t;
    t.rst_n = r; t.en = e; t.req = q; t.g = g; t.v = v; t.a = a; t.p = p;
    return t;
  endfunction

  // Observation packed as {grant, grant_valid, grant_addr, busy, preempt}.
  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got g=%b v=%b a=%0d busy=%b pre=%b, want g=%b v=%b a=%0d busy=%b pre=%b",
               name, act[8:5], act[4], act[3:2], act[1], act[0],
               exp[8:5], exp[4], exp[3:2], exp[1], exp[0]);
    end
  endtask

  function automatic logic [8:0] ex(logic [3:0] g, logic v, logic [1:0] a, logic p);
    return {g, v, a, v, p};
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // MAX_HOLD=2 instance: rotation, pointer search, coincident release, arb_en gating, re-request.
    tbl[0]  = mk(0, 1, 4'b0000, 4'b0000, 0, 0, 0);
    tbl[1]  = mk(1, 1, 4'b1111, 4'b0001, 1, 0, 0);
    tbl[2]  = mk(1, 1, 4'b1111, 4'b0001, 1, 0, 0);
    tbl[3]  = mk(1, 1, 4'b1111, 4'b0000, 0, 0, 1);
    tbl[4]  = mk(1, 1, 4'b1111, 4'b0010, 1, 1, 0);
    tbl[5]  = mk(1, 1, 4'b1111, 4'b0010, 1, 1, 0);
    tbl[6]  = mk(1, 1, 4'b1111, 4'b0000, 0, 1, 1);
    tbl[7]  = mk(1, 1, 4'b1111, 4'b0100, 1, 2, 0);
    tbl[8]  = mk(1, 1, 4'b1111, 4'b0100, 1, 2, 0);
    tbl[9]  = mk(1, 1, 4'b1111, 4'b0000, 0, 2, 1);
    tbl[10] = mk(1, 1, 4'b1111, 4'b1000, 1, 3, 0);
    tbl[11] = mk(1, 1, 4'b1111, 4'b1000, 1, 3, 0);
    tbl[12] = mk(1, 1, 4'b1111, 4'b0000, 0, 3, 1);
    tbl[13] = mk(1, 1, 4'b1111, 4'b0001, 1, 0, 0);
    tbl[14] = mk(1, 1, 4'b0010, 4'b0000, 0, 0, 0);
    tbl[15] = mk(1, 1, 4'b0010, 4'b0010, 1, 1, 0);
    tbl[16] = mk(1, 1, 4'b0000, 4'b0000, 0, 1, 0);
    tbl[17] = mk(1, 1, 4'b0011, 4'b0001, 1, 0, 0);
    tbl[18] = mk(1, 1, 4'b0010, 4'b0000, 0, 0, 0);
    tbl[19] = mk(1, 1, 4'b0010, 4'b0010, 1, 1, 0);
    tbl[20] = mk(1, 1, 4'b1000, 4'b0000, 0, 1, 0);
    tbl[21] = mk(1, 1, 4'b1000, 4'b1000, 1, 3, 0);
    tbl[22] = mk(1, 1, 4'b1000, 4'b1000, 1, 3, 0);
    tbl[23] = mk(1, 1, 4'b0000, 4'b0000, 0, 3, 0);
    tbl[24] = mk(1, 1, 4'b1010, 4'b0010, 1, 1, 0);
    tbl[25] = mk(1, 1, 4'b0100, 4'b0000, 0, 1, 0);
    tbl[26] = mk(1, 1, 4'b0100, 4'b0100, 1, 2, 0);
    tbl[27] = mk(1, 0, 4'b1111, 4'b0100, 1, 2, 0);
    tbl[28] = mk(1, 0, 4'b1111, 4'b0000, 0, 2, 1);
    tbl[29] = mk(1, 0, 4'b1111, 4'b0000, 0, 2, 0);
    tbl[30] = mk(1, 0, 4'b1111, 4'b0000, 0, 2, 0);
    tbl[31] = mk(1, 1, 4'b1111, 4'b1000, 1, 3, 0);
    tbl[32] = mk(1, 1, 4'b0000, 4'b0000, 0, 3, 0);
    tbl[33] = mk(1, 1, 4'b0000, 4'b0000, 0, 3, 0);
    tbl[34] = mk(1, 1, 4'b0100, 4'b0100, 1, 2, 0);
    tbl[35] = mk(1, 1, 4'b0000, 4'b0000, 0, 2, 0);
    tbl[36] = mk(1, 1, 4'b0100, 4'b0100, 1, 2, 0);
    tbl[37] = mk(1, 1, 4'b0000, 4'b0000, 0, 2, 0);
    tbl[38] = mk(1, 1, 4'b0101, 4'b0001, 1, 0, 0);
    tbl[39] = mk(1, 1, 4'b0000, 4'b0000, 0, 0, 0);

    for (int i = 0; i < 40; i++) begin
      rst_n  = tbl[i].rst_n;
      arb_en = tbl[i].en;
      req    = tbl[i].req;
      step();
      check($sformatf("vec%0d", i), {g2, v2, a2, b2, p2}, ex(tbl[i].g, tbl[i].v, tbl[i].a, tbl[i].p));
    end

    // MAX_HOLD=8: three-cycle ownership, gap, idle, then pointer advanced to 1.
    rst_n = 1'b0; arb_en = 1'b1; req = 4'b0000;
    step();
    rst_n = 1'b1;
    req = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("h8_grant%0d", i), {g8, v8, a8, b8, p8}, ex(4'b0001, 1, 0, 0));
    end
    req = 4'b0000;
    step();
    check("h8_gap", {g8, v8, a8, b8, p8}, ex(4'b0000, 0, 0, 0));
    step();
    check("h8_idle", {g8, v8, a8, b8, p8}, ex(4'b0000, 0, 0, 0));
    req = 4'b0011;
    step();
    check("h8_ptr1", {g8, v8, a8, b8, p8}, ex(4'b0010, 1, 1, 0));

    // Asynchronous reset between edges clears everything at once; ptr restarts at 0.
    #3 rst_n = 1'b0;
    #1;
    check("async_rst8", {g8, v8, a8, b8, p8}, ex(4'b0000, 0, 0, 0));
    check("async_rst2", {g2, v2, a2, b2, p2}, ex(4'b0000, 0, 0, 0));
    step();
    rst_n = 1'b1;
    step();
    check("rst_ptr0", {g8, v8, a8, b8, p8}, ex(4'b0001, 1, 0, 0));

    // MAX_HOLD=0 with a 2-bit counter: ownership persists well past counter saturation.
    req = 4'b0001;
    for (int i = 0; i < 7; i++) begin
      step();
      check($sformatf("h0_hold%0d", i), {g0, v0, a0, b0, p0}, ex(4'b0001, 1, 0, 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
